usage_averager: RTL and testbench

USAGE_AVERAGER -- requirements
Module: usage_averager

---
 rtl/usage_averager.sv | 119 +++++++++++
 tb/tb_usage_averager.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/usage_averager.sv
// Averages per-day talk/data usage over an ndays window via two parallel restoring dividers.
// done pulses DW+NW edges after the final sample; start is only taken in IDLE and day_valid is only taken in ACCUM.
module usage_averager #(
   parameter int DW = 6,
   parameter int NW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] ndays,
   input  logic          day_valid,
   input  logic [DW-1:0] talk_min,
   input  logic [DW-1:0] data_units,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] avgtalk,
   output logic [DW-1:0] avgdata
);
   localparam int SW = DW + NW;
   localparam int IW = $clog2(SW + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_DONE} state_t;

   state_t        r_state, w_state_nxt;
   logic [NW-1:0] r_ndays, r_cnt, w_cnt_inc;
   logic [IW-1:0] r_iter;
   logic [SW-1:0] r_sum [2];
   logic [NW-1:0] r_rem [2];
   logic [DW-1:0] r_avg [2];
   logic [DW-1:0] w_smp [2];
   logic [NW:0]   w_sh [2];
   logic [NW:0]   w_diff [2];
   logic          w_ge [2];
   logic [NW-1:0] w_rem_nxt [2];
   logic [SW-1:0] w_quo [2];
   logic          w_last_day, w_last_iter;

   assign w_smp[0]    = talk_min;
   assign w_smp[1]    = data_units;
   assign w_cnt_inc   = r_cnt + 1'b1;
   assign w_last_day  = day_valid && (w_cnt_inc == r_ndays);
   assign w_last_iter = (r_iter == IW'(SW - 1));
   assign avgtalk     = r_avg[0];
   assign avgdata     = r_avg[1];

   // Sum register doubles as dividend/quotient shift register during DIVIDE.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_sh[i]      = {r_rem[i], r_sum[i][SW-1]};
         w_diff[i]    = w_sh[i] - {1'b0, r_ndays};
         w_ge[i]      = (w_sh[i] >= {1'b0, r_ndays});
         w_rem_nxt[i] = w_ge[i] ? w_diff[i][NW-1:0] : w_sh[i][NW-1:0];
         w_quo[i]     = {r_sum[i][SW-2:0], w_ge[i]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != S_IDLE);
      done        = (r_state == S_DONE);
      case (r_state)
         S_IDLE:   if (start && (ndays != '0)) w_state_nxt = S_ACCUM;
         S_ACCUM:  if (w_last_day) w_state_nxt = S_DIVIDE;
         S_DIVIDE: if (w_last_iter) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ndays <= '0;
         r_cnt   <= '0;
         r_iter  <= '0;
         for (int i = 0; i < 2; i++) begin
            r_sum[i] <= '0;
            r_rem[i] <= '0;
            r_avg[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (ndays != '0)) begin
                  r_ndays <= ndays;
                  r_cnt   <= '0;
                  for (int i = 0; i < 2; i++) r_sum[i] <= '0;
               end
            end
            S_ACCUM: begin
               if (day_valid) begin
                  r_cnt  <= w_cnt_inc;
                  r_iter <= '0;
                  for (int i = 0; i < 2; i++) begin
                     r_sum[i] <= r_sum[i] + {{NW{1'b0}}, w_smp[i]};
                     r_rem[i] <= '0;
                  end
               end
            end
            S_DIVIDE: begin
               r_iter <= r_iter + 1'b1;
               for (int i = 0; i < 2; i++) begin
                  r_sum[i] <= w_quo[i];
                  r_rem[i] <= w_rem_nxt[i];
                  if (w_last_iter) r_avg[i] <= w_quo[i][DW-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_usage_averager.sv
// Random and directed stimulus for usage_averager, checked against integer sum/ndays reference.
module tb_usage_averager;
   localparam int DW = 6;
   localparam int NW = 5;
   localparam int SW = DW + NW;

   logic          clk = 1'b0;
   logic          rst_n, start, day_valid, busy, done;
   logic [NW-1:0] ndays;
   logic [DW-1:0] talk_min, data_units, avgtalk, avgdata;

   int n_checks = 0;
   int n_fail   = 0;
   int q_talk[$];
   int q_data[$];
   int q_gap[$];

   always #5 clk = ~clk;

   usage_averager #(.DW(DW), .NW(NW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ndays(ndays),
      .day_valid(day_valid), .talk_min(talk_min), .data_units(data_units),
      .busy(busy), .done(done), .avgtalk(avgtalk), .avgdata(avgdata)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full window from IDLE using q_talk/q_data/q_gap.
   task automatic run_window(input string tag, input int n, input bit poke_div, input bit poke_accum);
      int st = 0, sd = 0, k = 0, viol = 0, acc_done = 0, late_done = 0;
      logic [DW-1:0] pt, pd;
      pt = avgtalk;
      pd = avgdata;
      start = 1'b1;
      ndays = NW'(n);
      tick();
      start = 1'b0;
      chk({tag, ":busy_start"}, int'(busy), 1);
      for (int i = 0; i < n; i++) begin
         for (int g = 0; g < q_gap[i]; g++) begin
            day_valid  = 1'b0;
            talk_min   = DW'($urandom);
            data_units = DW'($urandom);
            if (poke_accum) begin
               start = 1'($urandom_range(0, 1));
               ndays = NW'($urandom);
            end
            tick();
            start = 1'b0;
            if (done) acc_done++;
         end
         day_valid  = 1'b1;
         talk_min   = DW'(q_talk[i]);
         data_units = DW'(q_data[i]);
         st += q_talk[i];
         sd += q_data[i];
         if (poke_accum) begin
            start = 1'($urandom_range(0, 1));
            ndays = NW'($urandom);
         end
         tick();
         start = 1'b0;
         if (done) acc_done++;
      end
      do begin
         day_valid  = 1'($urandom_range(0, 1));
         talk_min   = DW'($urandom);
         data_units = DW'($urandom);
         if (poke_div && k == 3) begin
            start = 1'b1;
            ndays = NW'(7);
         end
         tick();
         start = 1'b0;
         k++;
         if (!done && (avgtalk !== pt || avgdata !== pd)) viol++;
      end while (!done && k < 40);
      chk({tag, ":latency"}, k, SW);
      chk({tag, ":done_in_accum"}, acc_done, 0);
      chk({tag, ":avg_stable"}, viol, 0);
      chk({tag, ":avgtalk"}, int'(avgtalk), st / n);
      chk({tag, ":avgdata"}, int'(avgdata), sd / n);
      tick();
      chk({tag, ":done_one_cycle"}, int'(done), 0);
      chk({tag, ":idle_busy"}, int'(busy), 0);
      if (poke_div) begin
         for (int c = 0; c < 20; c++) begin
            tick();
            if (done || busy) late_done++;
         end
         chk({tag, ":no_second_done"}, late_done, 0);
      end
      day_valid = 1'b0;
   endtask

   initial begin
      int bad;
      int n;
      logic [DW-1:0] pt, pd;
      rst_n      = 1'b0;
      start      = 1'b0;
      ndays      = '0;
      day_valid  = 1'b0;
      talk_min   = '0;
      data_units = '0;
      #12;
      chk("rst:busy", int'(busy), 0);
      chk("rst:done", int'(done), 0);
      chk("rst:avgtalk", int'(avgtalk), 0);
      chk("rst:avgdata", int'(avgdata), 0);
      @(negedge clk);
      rst_n = 1'b1;

      q_talk = '{10, 20, 30, 40};
      q_data = '{5, 5, 5, 6};
      q_gap  = '{0, 0, 0, 0};
      run_window("basic4", 4, 1'b0, 1'b0);

      pt = avgtalk;
      pd = avgdata;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         day_valid  = 1'b1;
         talk_min   = DW'($urandom);
         data_units = DW'($urandom);
         tick();
         if (done || busy || avgtalk !== pt || avgdata !== pd) bad++;
      end
      day_valid = 1'b0;
      chk("idle_valid_ignored", bad, 0);

      q_talk = {}; q_data = {}; q_gap = {};
      for (int i = 0; i < 31; i++) begin
         q_talk.push_back(63);
         q_data.push_back(63);
         q_gap.push_back(0);
      end
      run_window("max31", 31, 1'b0, 1'b0);

      q_talk = '{0};
      q_data = '{63};
      q_gap  = '{5};
      run_window("gap1", 1, 1'b1, 1'b0);

      pt = avgtalk;
      pd = avgdata;
      bad = 0;
      start = 1'b1;
      ndays = '0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (busy || done) bad++;
         tick();
      end
      chk("ndays0:busy_done", bad, 0);
      chk("ndays0:avgtalk", int'(avgtalk), int'(pt));
      chk("ndays0:avgdata", int'(avgdata), int'(pd));

      start = 1'b1;
      ndays = NW'(3);
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         day_valid  = 1'b1;
         talk_min   = DW'(50);
         data_units = DW'(60);
         tick();
      end
      day_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst:avgtalk", int'(avgtalk), 0);
      chk("midrst:avgdata", int'(avgdata), 0);
      chk("midrst:busy", int'(busy), 0);
      chk("midrst:done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      q_talk = '{3, 3, 4};
      q_data = '{1, 2, 2};
      q_gap  = '{0, 0, 0};
      run_window("after_rst", 3, 1'b0, 1'b0);

      for (int w = 0; w < 20; w++) begin
         n = $urandom_range(1, 31);
         q_talk = {}; q_data = {}; q_gap = {};
         for (int i = 0; i < n; i++) begin
            q_talk.push_back($urandom_range(0, 63));
            q_data.push_back($urandom_range(0, 63));
            q_gap.push_back($urandom_range(0, 3));
         end
         run_window($sformatf("rand%0d", w), n, 1'b0, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
